// File: rtl/crc_engine.sv
// Parametrised CRC generator/checker. A beat accepted in ACCUM shows in crc one cycle later. The CRC is then shifted out DW bits per beat.
// Backpressure: din_ready is high only in ACCUM. In EMIT, dout and dout_valid hold while dout_ready is low.
// Optional residue check on flush: define CRC_CHECK_EN. When it is undefined, match is tied low.
module crc_engine #(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
  parameter int               DW      = 1,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CRC_W-1:0] crc,
  output logic             match,
  output logic             busy
);

  localparam int BEATS = CRC_W / DW;
  localparam int CNT_W = $clog2(BEATS) + 1;
  // Bits shifted in behind the CRC while it drains, so that crc ends at all-ones.
  localparam logic [CRC_W-1:0] FILL = {CRC_W{1'b1}} >> (CRC_W - DW);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_step, crc_emit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_beat;

  // DW serial LFSR steps, MSB of din first.
  always_comb begin
    crc_step = crc_q;
    for (int i = DW - 1; i >= 0; i--) begin
      if (din[i] ^ crc_step[CRC_W-1])
        crc_step = {crc_step[CRC_W-2:0], 1'b0} ^ POLY;
      else
        crc_step = {crc_step[CRC_W-2:0], 1'b0};
    end
  end

  assign crc_emit  = (crc_q << DW) | FILL;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = ACCUM;
      crc_d   = INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (din_valid) crc_d = crc_step;
          if (flush) begin
            state_d = EMIT;
            cnt_d   = '0;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            crc_d = crc_emit;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_beat) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CRC_CHECK_EN
  logic match_q;

  // Compare against the value crc takes on the flush edge, including any beat accepted in that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      match_q <= 1'b0;
    else if (start)
      match_q <= 1'b0;
    else if (state_q == ACCUM && flush)
      match_q <= (crc_d == RESIDUE);
  end

  assign match = match_q;
`else
  assign match = 1'b0;
`endif

  assign din_ready  = (state_q == ACCUM);
  assign dout_valid = (state_q == EMIT);
  assign busy       = (state_q != IDLE);
  assign crc        = crc_q;
  assign dout       = crc_q[CRC_W-1 -: DW];

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised CRC generator/checker with a valid/ready byte- or bit-wide input port and a serialised CRC output port. It accumulates a CRC over a framed data stream, then shifts the result out DW bits per cycle under backpressure, with an optional residue-check flag. It sits between the disc/serial datapath and the host interface and supersedes the fixed 1-bit CRC-16 engine.

## Interface
- CRC_W, 16, CRC register width (8..32)
- POLY, 16'h1021, generator polynomial, implicit x^CRC_W term omitted
- INIT, all-ones, register value on reset and on start
- DW, 1, bits per beat (1..8); CRC_W % DW must be 0
- RESIDUE, 0, expected remainder for check mode

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: reload INIT, enter ACCUM
- din  in  DW  data beat, MSB processed first
- din_valid  in  1  beat present
- din_ready  out  1  high only in ACCUM
- flush  in  1  end of frame; enter EMIT
- dout  out  DW  crc[CRC_W-1 -: DW]
- dout_valid  out  1  high only in EMIT
- dout_ready  in  1  sink accepts dout
- crc  out  CRC_W  current register
- match  out  1  crc == RESIDUE, captured on flush (see Configuration)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE: din_ready=0, dout_valid=0. start -> ACCUM with crc<=INIT, match<=0. flush ignored.
- ACCUM: din_ready=1. On din_valid: crc advances DW serial steps, MSB of din first; per step fb = bit ^ crc[CRC_W-1], crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0). flush -> EMIT; a beat valid in the same cycle is included first.
- EMIT: dout_valid=1. On dout_valid && dout_ready: crc <= {crc[CRC_W-DW-1:0], DW ones}, beat counter +1. After CRC_W/DW transfers -> IDLE; crc is then all-ones.
- start in any state wins over flush, din_valid and dout handshake: crc<=INIT, counter<=0, state ACCUM.
- Beat counter is log2(CRC_W/DW)+1 bits, cleared on start and on entry to EMIT; never wraps.
- reset_n low mid-frame: immediate return to IDLE, partial CRC lost.

## Timing
- Reset values: state IDLE, crc=INIT, din_ready=0, dout_valid=0, match=0, busy=0; dout therefore shows INIT's top DW bits.
- crc reflects an accepted beat one cycle after the accepting edge.
- start -> din_ready high next cycle.
- flush -> dout_valid high next cycle; match valid same cycle.
- dout/dout_valid stable while dout_ready low; one DW transfer per cycle with dout_ready held high.
- Minimum frame: start, flush, then CRC_W/DW emit cycles.

## Configuration
- CRC_CHECK_EN defined: on the flush edge, match <= (next crc == RESIDUE), where next crc includes any same-cycle beat; holds until next start or reset.
- CRC_CHECK_EN undefined: match tied 0, comparator and register removed.

## Test plan
- DW=8, defaults: start, bytes "123456789" (0x31..0x39) back-to-back, flush -> crc=0x29B1; dout 0x29 then 0xB1; crc=0xFFFF, IDLE.
- DW=1: start, 8 zero bits, flush -> crc=0xE1F0; dout streams 1110000111110000 over 16 cycles.
- CRC_CHECK_EN, DW=8: feed "123456789",0x29, with flush in same cycle as 0xB1 -> match=1; repeat with 0xB0 last -> match=0.
- Emit backpressure: dout_ready low 3 cycles after first beat -> dout=0x29 held, counter unchanged; release -> 0xB1 next.
- start asserted mid-EMIT after one transfer -> next cycle ACCUM, crc=0xFFFF, dout_valid=0.
- reset_n low during ACCUM mid-frame -> immediately busy=0, din_ready=0, crc=0xFFFF; flush afterwards ignored.
